// File: rtl/dense_layer_engine_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dense_layer_engine_if : operand / result / handshake bundle           |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface dense_layer_engine_if #(
  parameter int DW    = 16,
  parameter int N_IN  = 3,
  parameter int N_OUT = 3
);
  logic                    start;
  logic [N_IN*DW-1:0]      x_flat;
  logic [N_OUT*N_IN*DW-1:0] w_flat;
  logic [N_OUT*2*DW-1:0]   b_flat;
  logic [N_OUT*2*DW-1:0]   y_flat;
  logic                    busy;
  logic                    done;

  modport master (output start, x_flat, w_flat, b_flat, input y_flat, busy, done);
  modport slave  (input start, x_flat, w_flat, b_flat, output y_flat, busy, done);
endinterface
`default_nettype wire

// File: rtl/dense_layer_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dense_layer_engine : y = act(sat(W*x + b)), N_OUT parallel MAC lanes  |
// | Optional macro DENSE_RELU_EN selects ReLU, otherwise linear.  Rev 1.0 |
// +----------------------------------------------------------------------+
module dense_layer_engine #(
  parameter int DW    = 16,
  parameter int N_IN  = 3,
  parameter int N_OUT = 3
) (
  input  wire logic             clk,
  input  wire logic             rst,
  dense_layer_engine_if.slave   bus
);
  localparam int AW = 2*DW + $clog2(N_IN) + 1;
  localparam int YW = 2*DW;
  localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic signed [AW-1:0] c_SAT_MAX = {{(AW-YW+1){1'b0}}, {(YW-1){1'b1}}};
  localparam logic signed [AW-1:0] c_SAT_MIN = ~c_SAT_MAX;
  localparam logic [IW-1:0]        c_IDX_LAST = IW'(N_IN-1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [IW-1:0]         r_idx;
  logic signed [DW-1:0]  r_x   [N_IN];
  logic signed [DW-1:0]  r_w   [N_OUT][N_IN];
  logic signed [YW-1:0]  r_b   [N_OUT];
  logic signed [AW-1:0]  r_acc [N_OUT];
  logic [N_OUT*YW-1:0]   r_y;
  logic                  r_done;

  logic signed [YW-1:0]  w_mul [N_OUT];
  logic signed [AW-1:0]  w_sum [N_OUT];
  logic signed [YW-1:0]  w_sat [N_OUT];
  logic signed [YW-1:0]  w_y   [N_OUT];

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_RUN;
      S_RUN:   if (r_idx == c_IDX_LAST) w_next = S_OUT;
      S_OUT:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    for (int r = 0; r < N_OUT; r++) begin
      w_mul[r] = r_w[r][r_idx] * r_x[r_idx];
      w_sum[r] = r_acc[r] + {{(AW-YW){r_b[r][YW-1]}}, r_b[r]};
      if (w_sum[r] > c_SAT_MAX)      w_sat[r] = c_SAT_MAX[YW-1:0];
      else if (w_sum[r] < c_SAT_MIN) w_sat[r] = c_SAT_MIN[YW-1:0];
      else                           w_sat[r] = w_sum[r][YW-1:0];
`ifdef DENSE_RELU_EN
      w_y[r] = w_sat[r][YW-1] ? '0 : w_sat[r];
`else
      w_y[r] = w_sat[r];
`endif
    end
  end

  // Operand copies are only meaningful after a start, so they carry no reset.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && bus.start) begin
      for (int i = 0; i < N_IN; i++) r_x[i] <= bus.x_flat[i*DW +: DW];
      for (int r = 0; r < N_OUT; r++) begin
        for (int i = 0; i < N_IN; i++) r_w[r][i] <= bus.w_flat[(r*N_IN+i)*DW +: DW];
        r_b[r] <= bus.b_flat[r*YW +: YW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_done  <= 1'b0;
      r_y     <= '0;
      for (int r = 0; r < N_OUT; r++) r_acc[r] <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_idx <= '0;
            for (int r = 0; r < N_OUT; r++) r_acc[r] <= '0;
          end
        end
        S_RUN: begin
          for (int r = 0; r < N_OUT; r++)
            r_acc[r] <= r_acc[r] + {{(AW-YW){w_mul[r][YW-1]}}, w_mul[r]};
          r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
        end
        S_OUT: begin
          for (int r = 0; r < N_OUT; r++) r_y[r*YW +: YW] <= w_y[r];
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (r_state != S_IDLE);
  assign bus.done   = r_done;
  assign bus.y_flat = r_y;
endmodule
`default_nettype wire
